cdb_broadcast_scheduler: RTL and testbench

//  Shares the single Common Data Bus between the three result producers of the Tomasulo core.
//  The producers are the sum/sub ULA, the load/store ULA and the data RAM read port.

---
 rtl/cdb_broadcast_scheduler_if.sv | 52 +++++
 rtl/cdb_broadcast_scheduler.sv | 159 +++++++++++++++
 tb/tb_cdb_broadcast_scheduler.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/cdb_broadcast_scheduler_if.sv
// Common Data Bus scheduler bundle: three result producers with valid/ready
// handshakes, a broadcast hold, and the registered CDB outputs.
interface cdb_broadcast_scheduler_if #(
  parameter int DATA_W = 16,
  parameter int TAG_W  = 3
);
  logic              alu_valid;
  logic [TAG_W-1:0]  alu_tag;
  logic [DATA_W-1:0] alu_data;
  logic              alu_ready;

  logic              ldsd_valid;
  logic [TAG_W-1:0]  ldsd_tag;
  logic [DATA_W-1:0] ldsd_data;
  logic              ldsd_ready;

  logic              mem_valid;
  logic [TAG_W-1:0]  mem_tag;
  logic [DATA_W-1:0] mem_data;
  logic              mem_ready;

  logic              hold;

  logic              cdb_valid;
  logic [TAG_W-1:0]  cdb_tag;
  logic [DATA_W-1:0] cdb_data;
  logic [1:0]        cdb_src;

  // Producer / consumer side
  modport master (
    output alu_valid, alu_tag, alu_data,
    input  alu_ready,
    output ldsd_valid, ldsd_tag, ldsd_data,
    input  ldsd_ready,
    output mem_valid, mem_tag, mem_data,
    input  mem_ready,
    output hold,
    input  cdb_valid, cdb_tag, cdb_data, cdb_src
  );

  // Scheduler side
  modport slave (
    input  alu_valid, alu_tag, alu_data,
    output alu_ready,
    input  ldsd_valid, ldsd_tag, ldsd_data,
    output ldsd_ready,
    input  mem_valid, mem_tag, mem_data,
    output mem_ready,
    input  hold,
    output cdb_valid, cdb_tag, cdb_data, cdb_src
  );
endinterface

// File: rtl/cdb_broadcast_scheduler.sv
// Common Data Bus broadcast scheduler for the Tomasulo core.
// Three producers (alu=0, ldsd=1, mem=2) each feed a DEPTH-entry FIFO; one
// head per cycle is granted and registered onto the CDB as {tag, data, src}.
// Optional build macro CDB_MEM_PRIORITY_EN: a non-empty mem FIFO always wins
// and alu/ldsd round-robin between themselves; default is a 3-way round-robin.
module cdb_broadcast_scheduler #(
  parameter int DATA_W = 16,
  parameter int TAG_W  = 3,
  parameter int DEPTH  = 2
) (
  input  logic clock,
  input  logic reset,
  cdb_broadcast_scheduler_if.slave bus
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam int ENT_W = TAG_W + DATA_W;
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);
  localparam logic [1:0] SRC_ALU  = 2'd0;
  localparam logic [1:0] SRC_LDSD = 2'd1;
  localparam logic [1:0] SRC_MEM  = 2'd2;

  logic [2:0]            in_vld;
  logic [2:0]            rdy;
  logic [2:0]            push;
  logic [2:0]            pop;
  logic [2:0]            not_empty;
  logic [2:0][ENT_W-1:0] in_ent;
  logic [2:0][ENT_W-1:0] head_ent;

  logic [1:0]            last_p0;
  logic                  grant_vld;
  logic [1:0]            grant_src;
  logic                  adv_ptr;

  logic                  vld_p1;
  logic [TAG_W-1:0]      tag_p1;
  logic [DATA_W-1:0]     data_p1;
  logic [1:0]            src_p1;

  assign in_vld    = {bus.mem_valid, bus.ldsd_valid, bus.alu_valid};
  assign in_ent[0] = {bus.alu_tag,  bus.alu_data};
  assign in_ent[1] = {bus.ldsd_tag, bus.ldsd_data};
  assign in_ent[2] = {bus.mem_tag,  bus.mem_data};

  // Ready comes from the registered count only, so a valid while full is dropped.
  assign push = in_vld & rdy;

  assign bus.alu_ready  = rdy[0];
  assign bus.ldsd_ready = rdy[1];
  assign bus.mem_ready  = rdy[2];

  generate
    for (genvar i = 0; i < 3; i++) begin : g_fifo
      logic [ENT_W-1:0] store [DEPTH];
      logic [PTR_W-1:0] wr_ptr;
      logic [PTR_W-1:0] rd_ptr;
      logic [CNT_W-1:0] cnt;

      assign rdy[i]       = (cnt < FULL);
      assign not_empty[i] = (cnt != '0);
      assign head_ent[i]  = store[rd_ptr];

      // Pointer and occupancy bookkeeping; simultaneous push and pop keep cnt.
      always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
          wr_ptr <= '0;
          rd_ptr <= '0;
          cnt    <= '0;
        end else begin
          if (push[i]) wr_ptr <= wr_ptr + 1'b1;
          if (pop[i])  rd_ptr <= rd_ptr + 1'b1;
          if (push[i] && !pop[i])      cnt <= cnt + 1'b1;
          else if (!push[i] && pop[i]) cnt <= cnt - 1'b1;
        end
      end

      // Result storage, written at the tail on every accepted push.
      always_ff @(posedge clock) begin
        if (push[i]) store[wr_ptr] <= in_ent[i];
      end
    end
  endgenerate

`ifdef CDB_MEM_PRIORITY_EN
  // mem wins outright; alu and ldsd alternate using the last non-mem grant.
  function automatic logic [2:0] pick(input logic [2:0] req, input logic [1:0] last);
    pick = 3'b000;
    if (req[2]) begin
      pick = {1'b1, SRC_MEM};
    end else if (last == SRC_ALU) begin
      if (req[1])      pick = {1'b1, SRC_LDSD};
      else if (req[0]) pick = {1'b1, SRC_ALU};
    end else begin
      if (req[0])      pick = {1'b1, SRC_ALU};
      else if (req[1]) pick = {1'b1, SRC_LDSD};
    end
  endfunction
`else
  // Round-robin search 0->1->2->0 starting just after the last granted source.
  function automatic logic [2:0] pick(input logic [2:0] req, input logic [1:0] last);
    logic [1:0] idx;
    logic       found;
    pick  = 3'b000;
    found = 1'b0;
    idx   = last;
    for (int k = 0; k < 3; k++) begin
      idx = (idx == SRC_MEM) ? SRC_ALU : idx + 2'd1;
      if (!found && req[idx]) begin
        pick  = {1'b1, idx};
        found = 1'b1;
      end
    end
  endfunction
`endif

  // Arbitration: choose a winner unless held, pop its head, decide pointer update.
  always_comb begin
    grant_vld = 1'b0;
    grant_src = SRC_ALU;
    pop       = 3'b000;
    adv_ptr   = 1'b0;
    if (!bus.hold) begin
      {grant_vld, grant_src} = pick(not_empty, last_p0);
    end
    if (grant_vld) begin
      pop = 3'b001 << grant_src;
`ifdef CDB_MEM_PRIORITY_EN
      adv_ptr = (grant_src != SRC_MEM);
`else
      adv_ptr = 1'b1;
`endif
    end
  end

  // Grant stage: register the winning head onto the CDB; payload holds when idle.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      last_p0 <= SRC_MEM;
      vld_p1  <= 1'b0;
      tag_p1  <= '0;
      data_p1 <= '0;
      src_p1  <= SRC_ALU;
    end else begin
      vld_p1 <= grant_vld;
      if (adv_ptr) last_p0 <= grant_src;
      if (grant_vld) begin
        {tag_p1, data_p1} <= head_ent[grant_src];
        src_p1            <= grant_src;
      end
    end
  end

  assign bus.cdb_valid = vld_p1;
  assign bus.cdb_tag   = tag_p1;
  assign bus.cdb_data  = data_p1;
  assign bus.cdb_src   = src_p1;

endmodule

// File: tb/tb_cdb_broadcast_scheduler.sv
// Scoreboard bench for cdb_broadcast_scheduler: stimulus pushes the expected
// broadcast order into a queue, a negedge monitor pops and compares each CDB beat.
module tb_cdb_broadcast_scheduler;
  localparam int DATA_W = 16;
  localparam int TAG_W  = 3;
  localparam int DEPTH  = 2;

  typedef struct packed {
    logic [1:0]  src;
    logic [2:0]  tag;
    logic [15:0] data;
  } exp_t;

  logic clock = 1'b0;
  logic reset = 1'b0;

  cdb_broadcast_scheduler_if #(.DATA_W(DATA_W), .TAG_W(TAG_W)) bus ();

  cdb_broadcast_scheduler #(.DATA_W(DATA_W), .TAG_W(TAG_W), .DEPTH(DEPTH)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  // Monitor: every CDB beat must match the head of the expected queue.
  always @(negedge clock) begin
    exp_t e;
    if (reset === 1'b1 && bus.cdb_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL cdb_unexpected: got src=%0d tag=%0d data=%h, expected no broadcast",
                 bus.cdb_src, bus.cdb_tag, bus.cdb_data);
      end else begin
        e = exp_q.pop_front();
        check("cdb_beat", {11'd0, bus.cdb_src, bus.cdb_tag, bus.cdb_data}, {11'd0, e});
      end
    end
  end

  task automatic idle_in();
    bus.alu_valid  = 1'b0; bus.alu_tag  = '0; bus.alu_data  = '0;
    bus.ldsd_valid = 1'b0; bus.ldsd_tag = '0; bus.ldsd_data = '0;
    bus.mem_valid  = 1'b0; bus.mem_tag  = '0; bus.mem_data  = '0;
  endtask

  task automatic drive(input int src, input logic [2:0] tag, input logic [15:0] data);
    case (src)
      0: begin bus.alu_valid  = 1'b1; bus.alu_tag  = tag; bus.alu_data  = data; end
      1: begin bus.ldsd_valid = 1'b1; bus.ldsd_tag = tag; bus.ldsd_data = data; end
      default: begin bus.mem_valid = 1'b1; bus.mem_tag = tag; bus.mem_data = data; end
    endcase
  endtask

  task automatic exp_push(input logic [1:0] src, input logic [2:0] tag, input logic [15:0] data);
    exp_t e;
    e.src  = src;
    e.tag  = tag;
    e.data = data;
    exp_q.push_back(e);
  endtask

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b1;
    cyc();
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 30) begin
      @(negedge clock);
      n++;
    end
    repeat (4) @(negedge clock);
    check({name, "_drained"}, exp_q.size(), 0);
    exp_q.delete();
    cyc();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    idle_in();
    bus.hold = 1'b0;
    reset    = 1'b0;

    // Reset state
    repeat (2) @(negedge clock);
    check("rst_alu_ready",  bus.alu_ready,  1);
    check("rst_ldsd_ready", bus.ldsd_ready, 1);
    check("rst_mem_ready",  bus.mem_ready,  1);
    check("rst_cdb_valid",  bus.cdb_valid,  0);
    check("rst_cdb_tag",    bus.cdb_tag,    0);
    check("rst_cdb_data",   bus.cdb_data,   0);
    check("rst_cdb_src",    bus.cdb_src,    0);
    reset = 1'b1;
    cyc();

    // Single alu result, two-edge latency, one-cycle pulse, payload retained
    drive(0, 3'd3, 16'h0005);
    exp_push(2'd0, 3'd3, 16'h0005);
    cyc();
    idle_in();
    @(negedge clock);
    check("single_e0_valid", bus.cdb_valid, 0);
    @(negedge clock);
    check("single_e1_valid", bus.cdb_valid, 1);
    @(negedge clock);
    check("single_pulse_end", bus.cdb_valid, 0);
    check("single_tag_kept",  bus.cdb_tag,   3);
    check("single_data_kept", bus.cdb_data,  16'h0005);
    check("single_src_kept",  bus.cdb_src,   0);
    drain("single");

    // Simultaneous push from all three sources
    do_reset();
    drive(0, 3'd1, 16'h0011);
    drive(1, 3'd2, 16'h0022);
    drive(2, 3'd4, 16'h0044);
`ifdef CDB_MEM_PRIORITY_EN
    exp_push(2'd2, 3'd4, 16'h0044);
    exp_push(2'd0, 3'd1, 16'h0011);
    exp_push(2'd1, 3'd2, 16'h0022);
`else
    exp_push(2'd0, 3'd1, 16'h0011);
    exp_push(2'd1, 3'd2, 16'h0022);
    exp_push(2'd2, 3'd4, 16'h0044);
`endif
    cyc();
    idle_in();
    drain("simul");

    // Full alu FIFO: third push dropped
    do_reset();
    bus.hold = 1'b1;
    drive(0, 3'd1, 16'h000A);
    exp_push(2'd0, 3'd1, 16'h000A);
    cyc();
    drive(0, 3'd1, 16'h000B);
    exp_push(2'd0, 3'd1, 16'h000B);
    cyc();
    check("full_alu_ready", bus.alu_ready, 0);
    check("full_ldsd_ready", bus.ldsd_ready, 1);
    drive(0, 3'd1, 16'h000C);
    cyc();
    idle_in();
    check("full_alu_ready_after_drop", bus.alu_ready, 0);
    check("full_hold_no_bcast", bus.cdb_valid, 0);
    bus.hold = 1'b0;
    drain("full");

    // Fairness between alu and mem
    do_reset();
    bus.hold = 1'b1;
    drive(0, 3'd5, 16'hA001);
    drive(2, 3'd6, 16'hC001);
    cyc();
    drive(0, 3'd5, 16'hA002);
    drive(2, 3'd6, 16'hC002);
    cyc();
    idle_in();
`ifdef CDB_MEM_PRIORITY_EN
    exp_push(2'd2, 3'd6, 16'hC001);
    exp_push(2'd2, 3'd6, 16'hC002);
    exp_push(2'd0, 3'd5, 16'hA001);
    exp_push(2'd0, 3'd5, 16'hA002);
`else
    exp_push(2'd0, 3'd5, 16'hA001);
    exp_push(2'd2, 3'd6, 16'hC001);
    exp_push(2'd0, 3'd5, 16'hA002);
    exp_push(2'd2, 3'd6, 16'hC002);
`endif
    bus.hold = 1'b0;
    drain("fair");

    // Reset in the middle of operation discards buffered results
    do_reset();
    bus.hold = 1'b1;
    drive(0, 3'd1, 16'h0101);
    drive(1, 3'd2, 16'h0201);
    drive(2, 3'd3, 16'h0301);
    cyc();
    drive(0, 3'd1, 16'h0102);
    drive(1, 3'd2, 16'h0202);
    drive(2, 3'd3, 16'h0302);
    cyc();
    idle_in();
    check("midrst_alu_full",  bus.alu_ready,  0);
    check("midrst_ldsd_full", bus.ldsd_ready, 0);
    check("midrst_mem_full",  bus.mem_ready,  0);
`ifdef CDB_MEM_PRIORITY_EN
    exp_push(2'd2, 3'd3, 16'h0301);
`else
    exp_push(2'd0, 3'd1, 16'h0101);
`endif
    bus.hold = 1'b0;
    cyc();
    bus.hold = 1'b1;
    @(negedge clock);
    check("midrst_pre_valid", bus.cdb_valid, 1);
    #1;
    reset = 1'b0;
    #1;
    check("midrst_valid_cleared", bus.cdb_valid,  0);
    check("midrst_tag_cleared",   bus.cdb_tag,    0);
    check("midrst_alu_ready",     bus.alu_ready,  1);
    check("midrst_ldsd_ready",    bus.ldsd_ready, 1);
    check("midrst_mem_ready",     bus.mem_ready,  1);
    @(negedge clock);
    reset    = 1'b1;
    bus.hold = 1'b0;
    repeat (6) @(negedge clock);
    check("midrst_no_bcast",   bus.cdb_valid, 0);
    check("midrst_queue",      exp_q.size(),  0);
    check("midrst_alu_ready2", bus.alu_ready, 1);
    check("midrst_mem_ready2", bus.mem_ready, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
